spi_slave_regfile: RTL
======================

// Module: spi_slave_regfile
// PURPOSE
//  SPI mode-0 slave, downstream peer of spi_master. Decodes 24-bit frames {ID,ADDR,DATA}
//  MSB-first: ID 0x64 = write, 0x65 = read. Holds a DEPTH x 8 register file written over SPI
//  and readable by local logic.
//  All SPI inputs are asynchronous to clk: they are synchronised and edge-detected internally.
// PARAMETERS
//  DEPTH      16     number of 8-bit registers; addr >= DEPTH is out of range
//  SLAVE_IDW  8'h64  write ID accepted
//  SLAVE_IDR  8'h65  read ID accepted
// PORTS
//  clk        in   1  system clock
//  rst        in   1  reset; synchronous, active-high
//  ss         in   1  SPI slave select, active-low
//  sck        in   1  SPI clock; idle low, sample on rise, shift on fall
//  mosi       in   1  SPI data in
//  miso       out  1  SPI data out
//  host_addr  in   8  local read address
//  host_rdata out  8  regs[host_addr], registered (0x00 if out of range)
//  wr_valid   out  1  1-clk pulse on committed SPI write
//  wr_addr    out  8  address of last committed write
//  wr_data    out  8  data of last committed write
//  frame_done out  1  1-clk pulse when a valid 24-bit frame completes
//  id_err     out  1  1-clk pulse when the received ID matches neither IDW nor IDR
// BEHAVIOUR
//  - Reset: all regs, miso, host_rdata, wr_addr, wr_data = 0; pulses = 0; state = S_WAIT.
//  - Sync: 2-flop synchroniser on ss/sck/mosi; rise/fall detected on synced sck.
//    - Input-to-action latency is 3 clk.
//    - Requires each sck half-period >= 5 clk, i.e. master freq >= 4.
//  - States:
//    - S_WAIT: ignore everything until ss_s = 1, then go to S_IDLE.
//    - S_IDLE: on ss_s 1->0, clear bit_cnt (5 b) and shift_in, then go to S_ID.
//    - S_ID: rises 1..8 shift mosi into shift_in.
//      - After rise 8: IDW/IDR -> S_ADDR and latch rw; other -> pulse id_err, go to S_SKIP.
//    - S_ADDR: rises 9..16 capture addr.
//      - Read: after rise 16, load tx_sh = (addr<DEPTH) ? regs[addr] : 0x00.
//    - S_DATA: rises 17..24.
//      - Read: miso <= tx_sh[7] on the first fall after rise 16; shift on each later fall.
//      - Write: after rise 24, commit regs[addr] <= data if addr < DEPTH.
//        wr_valid/wr_addr/wr_data update only when the write commits.
//      - After rise 24: pulse frame_done for both read and write, then go to S_SKIP.
//    - S_SKIP: miso = 0, further sck edges ignored; ss_s 0->1 -> S_IDLE.
//  - ss_s rising before rise 24 aborts the frame:
//    - no write, no frame_done; miso <= 0; go to S_IDLE.
//  - miso is 0 whenever not in the read data phase.
//  - ss falling and sck rising seen in the same clk: frame starts, and that edge counts as rise 1.
//  - Reset mid-frame: go to S_WAIT; the rest of the frame is ignored until ss is seen high.
//  - SPI write and host read of the same address in one clk: host_rdata returns the old value,
//    and the new value from the next clk.
// CONFIGURATION
//  SPI_SLV_ERRCNT_EN defined:
//    - adds output err_cnt [7:0]: saturating count of id_err pulses plus aborted frames.
//    - err_cnt clears on rst.
//  Not defined: no err_cnt port, no counter logic; all other behaviour is identical.
// STRUCTURE
//  spi_defs.vh (shared with spi_master): SLAVE_IDW/IDR, frame length 24, state encodings.
//  Sub-module spi_slave_sync: 2-flop sync of ss/sck/mosi; outputs ss_s, mosi_s, sck_rise, sck_fall, ss_rise, ss_fall.
// TESTING
//  Pair with spi_master, freq = 4, on a shared clk; use a standalone driver for the error cases.
//  1 Write 0x64,0x03,0xA5 -> wr_valid 1 pulse, wr_addr 0x03, wr_data 0xA5; host_addr 3 -> 0xA5.
//  2 Then read 0x65,0x03 -> master rdata 0xA5, frame_done pulse, no wr_valid.
//  3 Write addr 0x20 (>= DEPTH) -> no wr_valid; read 0x20 -> master rdata 0x00.
//  4 ID 0x55 -> id_err pulse after rise 8; miso stays 0; no write.
//    - with SPI_SLV_ERRCNT_EN: err_cnt = 1.
//  5 ss raised after 20 rises of a write -> no write, no frame_done; next full frame still works.
//  6 rst asserted mid-frame with ss low -> outputs 0; rest of frame ignored; next frame after ss high is OK.

Source files
------------

// File: rtl/spi_slave_regfile_pkg.sv
// Shared constants for the SPI register-file slave: frame IDs, bit positions, FSM encodings.
// Optional feature macro: SPI_SLV_ERRCNT_EN (adds err_cnt output on spi_slave_regfile).
package spi_slave_regfile_pkg;

   localparam logic [7:0] SLAVE_IDW_DEF = 8'h64;
   localparam logic [7:0] SLAVE_IDR_DEF = 8'h65;

   localparam logic [4:0] BITS_ID    = 5'd8;
   localparam logic [4:0] BITS_ADDR  = 5'd16;
   localparam logic [4:0] BITS_FRAME = 5'd24;

   typedef logic [2:0] state_t;

   localparam logic [2:0] S_WAIT = 3'd0;
   localparam logic [2:0] S_IDLE = 3'd1;
   localparam logic [2:0] S_ID   = 3'd2;
   localparam logic [2:0] S_ADDR = 3'd3;
   localparam logic [2:0] S_DATA = 3'd4;
   localparam logic [2:0] S_SKIP = 3'd5;

   function automatic logic in_range(input logic [7:0] a, input int depth);
      return int'(a) < depth;
   endfunction

endpackage

// File: rtl/spi_slave_regfile_sync.sv
// Two-flop synchroniser for ss/sck/mosi plus edge detection on the synced ss and sck.
// ss resets low so a reset mid-frame cannot fake an ss falling edge.
module spi_slave_regfile_sync
   import spi_slave_regfile_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic ss,
   input  logic sck,
   input  logic mosi,
   output logic ss_s,
   output logic mosi_s,
   output logic sck_rise,
   output logic sck_fall,
   output logic ss_rise,
   output logic ss_fall
);

   logic ss_m, ss_d;
   logic sck_m, sck_s, sck_d;
   logic mosi_m;

   always_ff @(posedge clk) begin
      if (rst) begin
         ss_m   <= 1'b0;
         ss_s   <= 1'b0;
         ss_d   <= 1'b0;
         sck_m  <= 1'b0;
         sck_s  <= 1'b0;
         sck_d  <= 1'b0;
         mosi_m <= 1'b0;
         mosi_s <= 1'b0;
      end else begin
         ss_m   <= ss;
         ss_s   <= ss_m;
         ss_d   <= ss_s;
         sck_m  <= sck;
         sck_s  <= sck_m;
         sck_d  <= sck_s;
         mosi_m <= mosi;
         mosi_s <= mosi_m;
      end
   end

   assign sck_rise = sck_s & ~sck_d;
   assign sck_fall = ~sck_s & sck_d;
   assign ss_rise  = ss_s & ~ss_d;
   assign ss_fall  = ~ss_s & ss_d;

endmodule

// File: rtl/spi_slave_regfile.sv
// SPI mode-0 slave decoding {ID,ADDR,DATA} frames into a DEPTH x 8 register file.
// Optional feature macro: SPI_SLV_ERRCNT_EN adds err_cnt (saturating id_err + abort count).
//
// state  | meaning
// S_WAIT | after reset, wait for ss high before accepting a frame
// S_IDLE | ss high, wait for ss falling edge
// S_ID   | shifting in the 8-bit ID (rises 1..8)
// S_ADDR | shifting in the address (rises 9..16)
// S_DATA | write data in / read data out (rises 17..24)
// S_SKIP | frame finished or rejected, ignore sck until ss rises
module spi_slave_regfile
   import spi_slave_regfile_pkg::*;
#(
   parameter int         DEPTH     = 16,
   parameter logic [7:0] SLAVE_IDW = SLAVE_IDW_DEF,
   parameter logic [7:0] SLAVE_IDR = SLAVE_IDR_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ss,
   input  logic       sck,
   input  logic       mosi,
   output logic       miso,
   input  logic [7:0] host_addr,
   output logic [7:0] host_rdata,
   output logic       wr_valid,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       frame_done,
`ifdef SPI_SLV_ERRCNT_EN
   output logic [7:0] err_cnt,
`endif
   output logic       id_err
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic ss_s, mosi_s, sck_rise, sck_fall, ss_rise, ss_fall;

   spi_slave_regfile_sync u_sync (
      .clk      (clk),
      .rst      (rst),
      .ss       (ss),
      .sck      (sck),
      .mosi     (mosi),
      .ss_s     (ss_s),
      .mosi_s   (mosi_s),
      .sck_rise (sck_rise),
      .sck_fall (sck_fall),
      .ss_rise  (ss_rise),
      .ss_fall  (ss_fall)
   );

   state_t     state;
   logic [4:0] bit_cnt;
   logic [7:0] shift_in;
   logic [7:0] addr;
   logic [7:0] tx_sh;
   logic       rw;
   logic [7:0] regs [DEPTH];

   logic [4:0] cnt_nxt;
   logic [7:0] byte_nxt;
   logic       in_frame;

   assign cnt_nxt  = bit_cnt + 5'd1;
   assign byte_nxt = {shift_in[6:0], mosi_s};
   assign in_frame = (state == S_ID) || (state == S_ADDR) || (state == S_DATA);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_WAIT;
         bit_cnt    <= '0;
         shift_in   <= '0;
         addr       <= '0;
         tx_sh      <= '0;
         rw         <= 1'b0;
         miso       <= 1'b0;
         host_rdata <= '0;
         wr_valid   <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         frame_done <= 1'b0;
         id_err     <= 1'b0;
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else begin
         wr_valid   <= 1'b0;
         frame_done <= 1'b0;
         id_err     <= 1'b0;
         host_rdata <= in_range(host_addr, DEPTH) ? regs[host_addr[AW-1:0]] : 8'h00;

         if (in_frame && ss_rise) begin
            miso  <= 1'b0;
            state <= S_IDLE;
         end else begin
            case (state)
               S_WAIT: begin
                  miso <= 1'b0;
                  if (ss_s) state <= S_IDLE;
               end
               S_IDLE: begin
                  miso <= 1'b0;
                  if (ss_fall) begin
                     state <= S_ID;
                     // an sck rise seen together with ss fall is already bit 1
                     if (sck_rise) begin
                        bit_cnt  <= 5'd1;
                        shift_in <= {7'b0, mosi_s};
                     end else begin
                        bit_cnt  <= '0;
                        shift_in <= '0;
                     end
                  end
               end
               S_ID, S_ADDR, S_DATA: begin
                  if (sck_rise) begin
                     bit_cnt  <= cnt_nxt;
                     shift_in <= byte_nxt;
                     if (state == S_ID && cnt_nxt == BITS_ID) begin
                        if (byte_nxt == SLAVE_IDW || byte_nxt == SLAVE_IDR) begin
                           rw    <= (byte_nxt == SLAVE_IDR);
                           state <= S_ADDR;
                        end else begin
                           id_err <= 1'b1;
                           state  <= S_SKIP;
                        end
                     end else if (state == S_ADDR && cnt_nxt == BITS_ADDR) begin
                        addr  <= byte_nxt;
                        tx_sh <= in_range(byte_nxt, DEPTH) ? regs[byte_nxt[AW-1:0]] : 8'h00;
                        state <= S_DATA;
                     end else if (state == S_DATA && cnt_nxt == BITS_FRAME) begin
                        if (!rw && in_range(addr, DEPTH)) begin
                           regs[addr[AW-1:0]] <= byte_nxt;
                           wr_valid <= 1'b1;
                           wr_addr  <= addr;
                           wr_data  <= byte_nxt;
                        end
                        frame_done <= 1'b1;
                        miso       <= 1'b0;
                        state      <= S_SKIP;
                     end
                  end else if (sck_fall && state == S_DATA && rw) begin
                     miso  <= tx_sh[7];
                     tx_sh <= {tx_sh[6:0], 1'b0};
                  end
               end
               S_SKIP: begin
                  miso <= 1'b0;
                  if (ss_rise) state <= S_IDLE;
               end
               default: begin
                  miso  <= 1'b0;
                  state <= S_WAIT;
               end
            endcase
         end
      end
   end

`ifdef SPI_SLV_ERRCNT_EN
   logic abort_evt;
   assign abort_evt = in_frame && ss_rise;

   always_ff @(posedge clk) begin
      if (rst)
         err_cnt <= '0;
      else if ((id_err || abort_evt) && err_cnt != 8'hFF)
         err_cnt <= err_cnt + 8'd1;
   end
`endif

endmodule
